// File: rtl/str_msg_decoder_pkg.sv
// Shared definitions for the packed-ASCII message decoder: the fixed message
// table, FSM state type, index width and the byte case-fold helper.
package str_msg_pkg;

  localparam int MSG_IDX_W = 2;
  localparam int MSG_NUM   = 4;

  // Entry i is "Mesi", packed exactly as a string literal assigned to a reg.
  localparam logic [0:MSG_NUM-1][31:0] MSG_TABLE = {"Mes0", "Mes1", "Mes2", "Mes3"};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MATCH   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Map 'a'..'z' to 'A'..'Z'; every other byte passes through unchanged.
  function automatic logic [7:0] to_upper_byte(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/str_msg_decoder_if.sv
// Character-in / result-out bus of the message decoder.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge when
// valid and ready are both 1. A source holds valid and its payload stable until
// the transfer; valid never waits on ready. ch_data/ch_last mean nothing while
// ch_valid=0. res_* stay stable while res_valid=1 and res_ready=0.
interface str_msg_decoder_if #(
  parameter int WORD_BYTES = 4
) ();
  logic                    ch_valid;
  logic                    ch_ready;
  logic [7:0]              ch_data;
  logic                    ch_last;
  logic                    res_valid;
  logic                    res_ready;
  logic [8*WORD_BYTES-1:0] res_word;
  logic                    res_hit;
  logic [1:0]              res_idx;
  logic                    res_ovf;

  modport master (
    output ch_valid, ch_data, ch_last, res_ready,
    input  ch_ready, res_valid, res_word, res_hit, res_idx, res_ovf
  );

  modport slave (
    input  ch_valid, ch_data, ch_last, res_ready,
    output ch_ready, res_valid, res_word, res_hit, res_idx, res_ovf
  );
endinterface

// File: rtl/str_msg_decoder_match.sv
// Combinational compare of a packed word against every MSG_TABLE entry.
// Table entries are zero-extended to the word width. Build option
// STR_DEC_CASE_FOLD_EN folds both operands to upper case before comparing.
module str_msg_match
  import str_msg_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic [8*WORD_BYTES-1:0] word,
  output logic                    hit,
  output logic [MSG_IDX_W-1:0]    idx
);
  localparam int W = 8 * WORD_BYTES;

  // Operand form used for comparison: folded when the option is built in.
  function automatic logic [W-1:0] cmp_form(input logic [W-1:0] w);
`ifdef STR_DEC_CASE_FOLD_EN
    logic [W-1:0] f;
    f = '0;
    for (int b = 0; b < WORD_BYTES; b++) f[8*b +: 8] = to_upper_byte(w[8*b +: 8]);
    return f;
`else
    return w;
`endif
  endfunction

  // Parallel compare; table entries are distinct so the lowest hit is the only hit.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < MSG_NUM; i++) begin
      if (!hit && (cmp_form(word) == cmp_form(W'(MSG_TABLE[i])))) begin
        hit = 1'b1;
        idx = MSG_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/str_msg_decoder.sv
// Receive side of the packed-ASCII message path. Characters are shifted into a
// right-justified word (string-literal semantics, oldest characters truncated on
// overflow), then matched against "Mes0".."Mes3".
// Build option: STR_DEC_CASE_FOLD_EN makes the table compare case-insensitive.
module str_msg_decoder
  import str_msg_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  str_msg_decoder_if.slave    bus,
  output state_t              dbg_state
);
  localparam int W     = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_BYTES + 1);

  state_t                 state;
  logic                   ch_ready_q;
  logic [W-1:0]           word_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_q;
  logic                   cmp_done_q;
  logic                   hit_q;
  logic [MSG_IDX_W-1:0]   idx_q;
  logic                   res_valid_q;
  logic [W-1:0]           res_word_q;
  logic                   res_hit_q;
  logic [MSG_IDX_W-1:0]   res_idx_q;
  logic                   res_ovf_q;

  logic                   m_hit;
  logic [MSG_IDX_W-1:0]   m_idx;
  logic                   ch_fire;

  assign ch_fire = bus.ch_valid & ch_ready_q;

  str_msg_match #(.WORD_BYTES(WORD_BYTES)) u_match (
    .word (word_q),
    .hit  (m_hit),
    .idx  (m_idx)
  );

  // Collect -> compare (registered) -> load result -> hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch_ready_q  <= 1'b0;
      word_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      cmp_done_q  <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      res_word_q  <= '0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ch_ready_q <= 1'b1;
          if (ch_fire) begin
            word_q <= W'(bus.ch_data);
            cnt_q  <= CNT_W'(1);
            ovf_q  <= 1'b0;
            if (bus.ch_last) begin
              state      <= MATCH;
              ch_ready_q <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (ch_fire) begin
            word_q <= {word_q[W-9:0], bus.ch_data};
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
            if (bus.ch_last) begin
              state      <= MATCH;
              ch_ready_q <= 1'b0;
            end
          end
        end
        MATCH: begin
          // First cycle registers the compare, second publishes the result.
          if (!cmp_done_q) begin
            hit_q      <= m_hit & ~ovf_q;
            idx_q      <= (m_hit & ~ovf_q) ? m_idx : '0;
            cmp_done_q <= 1'b1;
          end else begin
            res_word_q  <= word_q;
            res_ovf_q   <= ovf_q;
            res_hit_q   <= hit_q;
            res_idx_q   <= idx_q;
            res_valid_q <= 1'b1;
            cmp_done_q  <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            word_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ch_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ch_ready  = ch_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_word  = res_word_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_ovf   = res_ovf_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_str_msg_decoder.sv
// Scoreboard bench for str_msg_decoder: directed strings from the test plan
// followed by randomized strings, each checked against a string-level model.
module tb_str_msg_decoder;
  import str_msg_pkg::*;

  localparam int WB = 4;
  localparam int W  = 8 * WB;
  localparam int EW = W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  str_msg_decoder_if #(.WORD_BYTES(WB)) bus ();
  state_t dbg_state;

  str_msg_decoder #(.WORD_BYTES(WB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    tx_q[$];
  int last_acc_cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] up(input logic [7:0] b);
    return (b >= "a" && b <= "z") ? b - 8'd32 : b;
  endfunction

  // Result of the string in tx_q: last WB characters right-justified,
  // overflow when longer than WB, hit only on an exact table string.
  function automatic logic [EW-1:0] model();
    logic [31:0] tbl[4];
    logic [W-1:0] w;
    logic [7:0] x, y;
    logic ovf, hit, eq;
    logic [1:0] idx;
    int len, first;
    tbl[0] = "Mes0"; tbl[1] = "Mes1"; tbl[2] = "Mes2"; tbl[3] = "Mes3";
    len = tx_q.size();
    first = (len > WB) ? len - WB : 0;
    w = '0;
    for (int k = first; k < len; k++) w = w | (W'(tx_q[k]) << (8 * (len - 1 - k)));
    ovf = (len > WB);
    hit = 1'b0;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      eq = 1'b1;
      for (int b = 0; b < WB; b++) begin
        x = w[8*b +: 8];
        y = (b < 4) ? tbl[i][8*b +: 8] : 8'h00;
`ifdef STR_DEC_CASE_FOLD_EN
        x = up(x);
        y = up(y);
`endif
        if (x != y) eq = 1'b0;
      end
      if (!ovf && !hit && eq) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
    return {ovf, hit, idx, w};
  endfunction

  // ---------------- result-ready driver ----------------
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_v, prev_xfer;
    logic [EW-1:0] snap, got;
    prev_v = 1'b0;
    prev_xfer = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_xfer = 1'b0;
      end else begin
        got = {bus.res_ovf, bus.res_hit, bus.res_idx, bus.res_word};
        if (prev_xfer) check("post_consume{valid,ready}", 64'({bus.res_valid, bus.ch_ready}), 64'(2'b01));
        if (bus.res_valid) begin
          check("ch_ready_in_hold", 64'(bus.ch_ready), 64'(0));
          if (!prev_v) check("latency", 64'(cyc - last_acc_cyc), 64'(2));
          else check("hold_stable", 64'(got), 64'(snap));
          if (bus.res_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_result: got %0h expected none", got);
            end else begin
              check("result{ovf,hit,idx,word}", 64'(got), 64'(exp_q.pop_front()));
            end
          end
        end
        prev_v = bus.res_valid;
        prev_xfer = bus.res_valid && bus.res_ready;
        snap = got;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input string s);
    tx_q.delete();
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  // Sends tx_q; when with_last=0 the string is left unterminated.
  task automatic send_str(input bit rand_gap, input bit with_last);
    int len, t;
    bit acc, rd;
    len = tx_q.size();
    for (int k = 0; k < len; k++) begin
      if (rand_gap) begin
        repeat ($urandom_range(0, 2)) begin
          bus.ch_valid = 1'b0;
          bus.ch_data  = 8'($urandom);
          bus.ch_last  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.ch_valid = 1'b1;
      bus.ch_data  = tx_q[k];
      bus.ch_last  = with_last && (k == len - 1);
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        rd = bus.ch_ready;
        @(posedge clk); #1;
        acc = rd;
        t++;
      end
      if (!acc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ch_accept_timeout: got ch_ready=0 expected 1 within 200 cycles");
        bus.ch_valid = 1'b0;
        return;
      end
      if (with_last && k == len - 1) begin
        last_acc_cyc = cyc;
        exp_q.push_back(model());
      end
    end
    bus.ch_valid = 1'b0;
    bus.ch_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_outputs"},
          64'({bus.ch_ready, bus.res_valid, bus.res_word, bus.res_hit, bus.res_idx, bus.res_ovf}),
          64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int t, kind, n;
    logic [7:0] c;
    string ent;
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    bus.ch_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;
    check("ch_ready_before_first_edge", 64'(bus.ch_ready), 64'(0));
    @(posedge clk); #1;
    check("ch_ready_after_first_edge", 64'(bus.ch_ready), 64'(1));

    // Directed strings, always-ready consumer.
    rdy_mode = 0;
    load("Mes1");  send_str(1'b0, 1'b1); drain();
    load("hi");    send_str(1'b0, 1'b1); drain();
    load("XMes2"); send_str(1'b0, 1'b1); drain();
    load("MES2");  send_str(1'b0, 1'b1); drain();
    load("Mes");   tx_q.push_front(8'h00); send_str(1'b0, 1'b1); drain();

    // Back-pressure: result held while consumer is stalled and a char is offered.
    rdy_mode = 2;
    load("Mes3");
    send_str(1'b0, 1'b1);
    t = 0;
    while (!bus.res_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("hold_reached", 64'(bus.res_valid), 64'(1));
    bus.ch_valid = 1'b1;
    bus.ch_data  = "Z";
    bus.ch_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.ch_valid = 1'b0;
    bus.ch_last  = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset in the middle of a string, then the full string again.
    load("Me");
    send_str(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load("Mes0"); send_str(1'b0, 1'b1); drain();

    // Randomized strings with gaps and a random-ready consumer.
    rdy_mode = 1;
    for (int s = 0; s < 60; s++) begin
      kind = $urandom_range(0, 4);
      tx_q.delete();
      case (kind)
        0, 1: begin
          ent = $sformatf("Mes%0d", $urandom_range(0, 3));
          for (int i = 0; i < 4; i++) begin
            c = ent[i];
            if (kind == 1 && c >= "A" && $urandom_range(0, 1)) c = c ^ 8'h20;
            tx_q.push_back(c);
          end
        end
        2: begin
          n = $urandom_range(1, 6);
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(48, 122)));
        end
        3: begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 1) ? 0 : $urandom_range(65, 90)));
          ent = $sformatf("Mes%0d", $urandom_range(0, 3));
          for (int i = 0; i < 4; i++) tx_q.push_back(ent[i]);
        end
        default: begin
          ent = "Mes";
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) tx_q.push_back(ent[i]);
        end
      endcase
      send_str(1'b1, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
